// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input, edge-detector pulse and consumer read port of the receive controller.
interface uart_rx_if #(parameter int DATA_BITS = 8);
   logic                 serial_in;
   logic                 start_bit_detected;
   logic                 data_read;
   logic [DATA_BITS-1:0] rx_data;
   logic                 data_ready;
   logic                 parity_error;
   logic                 framing_error;
   logic                 overrun_error;
   logic                 busy;
   modport master (
      output serial_in, start_bit_detected, data_read,
      input  rx_data, data_ready, parity_error, framing_error, overrun_error, busy
   );
   modport slave (
      input  serial_in, start_bit_detected, data_read,
      output rx_data, data_ready, parity_error, framing_error, overrun_error, busy
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: parametrised UART frame receiver with bit timer, shift register,
// parity/stop checking and a single-entry receive buffer with overrun detection.
module uart_rx_ctrl #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 10,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0
) (
   input logic      clk,
   input logic      rst,
   uart_rx_if.slave bus
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, LOAD} state_t;
   state_t               state;
   logic [TW-1:0]        timer;
   logic [3:0]           cnt;
   logic [DATA_BITS-1:0] sr;
   logic                 pfail;
   logic                 sfail;
   logic [DATA_BITS-1:0] rx_data;
   logic                 data_ready;
   logic                 parity_error;
   logic                 framing_error;
   logic                 overrun_error;
   logic                 tick;
   assign tick              = timer == T_LAST;
   assign bus.rx_data       = rx_data;
   assign bus.data_ready    = data_ready;
   assign bus.parity_error  = parity_error;
   assign bus.framing_error = framing_error;
   assign bus.overrun_error = overrun_error;
   assign bus.busy          = state != IDLE;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         timer         <= '0;
         cnt           <= '0;
         sr            <= '0;
         pfail         <= 1'b0;
         sfail         <= 1'b0;
         rx_data       <= '0;
         data_ready    <= 1'b0;
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
         overrun_error <= 1'b0;
      end else begin
         // a read in LOAD is folded into the buffer update below
         if (bus.data_read && state != LOAD) begin
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
         end
         timer <= timer + 1'b1;
         case (state)
            IDLE: begin
               timer <= '0;
               cnt   <= '0;
               if (bus.start_bit_detected) begin
                  state <= START;
                  pfail <= 1'b0;
                  sfail <= 1'b0;
               end
            end
            START: if (timer == T_HALF) begin
               timer <= '0;
               cnt   <= '0;
               state <= bus.serial_in ? IDLE : DATA;
            end
            DATA: if (tick) begin
               timer <= '0;
               sr    <= {bus.serial_in, sr[DATA_BITS-1:1]};
               cnt   <= cnt == LAST_DATA ? '0 : cnt + 1'b1;
               if (cnt == LAST_DATA) state <= PARITY_EN != 0 ? PARITY : STOP;
            end
            PARITY: if (tick) begin
               timer <= '0;
               cnt   <= '0;
               state <= STOP;
               if (bus.serial_in != (PARITY_ODD != 0 ? ~^sr : ^sr)) pfail <= 1'b1;
            end
            STOP: if (tick) begin
               timer <= '0;
               cnt   <= cnt == LAST_STOP ? '0 : cnt + 1'b1;
               if (!bus.serial_in) sfail <= 1'b1;
               if (cnt == LAST_STOP) state <= LOAD;
            end
            LOAD: begin
               timer         <= '0;
               cnt           <= '0;
               state         <= IDLE;
               framing_error <= sfail;
               parity_error  <= pfail;
               if (!sfail) begin
                  rx_data    <= sr;
                  data_ready <= 1'b1;
                  if (bus.data_read) overrun_error <= 1'b0;
                  else if (data_ready) overrun_error <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frames on a default instance and a 7-bit odd-parity,
// two-stop-bit instance, checked against hand-computed cycle timing and flags.
module tb_uart_rx_ctrl;
   localparam int CPB  = 10;
   localparam int HALF = CPB / 2;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sel = 1'b0;
   logic ser = 1'b1;
   logic stb = 1'b0;
   logic rd  = 1'b0;
   int n_chk = 0;
   int n_err = 0;
   uart_rx_if #(.DATA_BITS(8)) b0 ();
   uart_rx_if #(.DATA_BITS(7)) b1 ();
   uart_rx_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(CPB)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
   uart_rx_ctrl #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(1))
      dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
   assign b0.serial_in          = sel ? 1'b1 : ser;
   assign b0.start_bit_detected = sel ? 1'b0 : stb;
   assign b0.data_read          = sel ? 1'b0 : rd;
   assign b1.serial_in          = sel ? ser : 1'b1;
   assign b1.start_bit_detected = sel ? stb : 1'b0;
   assign b1.data_read          = sel ? rd : 1'b0;
   logic [8:0] o_data;
   logic o_rdy, o_pe, o_fe, o_oe, o_busy;
   assign o_data = sel ? {2'b0, b1.rx_data} : {1'b0, b0.rx_data};
   assign o_rdy  = sel ? b1.data_ready : b0.data_ready;
   assign o_pe   = sel ? b1.parity_error : b0.parity_error;
   assign o_fe   = sel ? b1.framing_error : b0.framing_error;
   assign o_oe   = sel ? b1.overrun_error : b0.overrun_error;
   assign o_busy = sel ? b1.busy : b0.busy;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [15:0] mk(input logic [8:0] d, input int nd, input int pe,
                                      input logic pb, input int ns, input logic sv);
      logic [15:0] b;
      b    = '1;
      b[0] = 1'b0;
      for (int i = 0; i < nd; i++) b[1+i] = d[i];
      if (pe != 0) b[1+nd] = pb;
      for (int s = 0; s < ns; s++) b[1+nd+pe+s] = sv;
      return b;
   endfunction
   // Drives one frame bit-window at a time; cycle c's inputs are set on the negedge inside cycle c.
   task automatic frame(input logic w, input logic [15:0] bits, input int nb, input int extra,
                        input int rst_at, input logic hold_rd, input int q,
                        output int rise, output logic bq);
      logic prev;
      sel  = w;
      rise = -1;
      bq   = 1'bx;
      prev = o_rdy;
      for (int c = 0; c < nb * CPB + 3; c++) begin
         @(negedge clk);
         if (rise < 0 && o_rdy && !prev) rise = c;
         prev = o_rdy;
         if (c == q) bq = o_busy;
         ser = c < nb * CPB ? bits[c/CPB] : 1'b1;
         stb = c == 0 || c == extra;
         rd  = hold_rd && c <= HALF + (nb - 1) * CPB + 1;
         if (c == rst_at) begin
            rst = 1'b1;
            #1;
            check("rst_data", 32'(o_data), 32'h0);
            check("rst_rdy", 32'(o_rdy), 32'h0);
            check("rst_flags", {29'b0, o_pe, o_fe, o_oe}, 32'h0);
            check("rst_busy", 32'(o_busy), 32'h0);
         end
         if (c == rst_at + 1) rst = 1'b0;
      end
      stb = 1'b0;
      rd  = 1'b0;
   endtask
   task automatic read_pulse();
      @(negedge clk);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
   endtask
   initial begin
      int   rise;
      logic bq;
      #1;
      check("reset_data", 32'(o_data), 32'h0);
      check("reset_flags", {28'b0, o_rdy, o_pe, o_fe, o_oe}, 32'h0);
      check("reset_busy", 32'(o_busy), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      frame(1'b0, mk(9'hA5, 8, 0, 1'b0, 1, 1'b1), 10, -1, -1, 1'b0, 50, rise, bq);
      check("a5_rise", 32'(rise), 32'd97);
      check("a5_busy_mid", 32'(bq), 32'h1);
      check("a5_data", 32'(o_data), 32'hA5);
      check("a5_flags", {29'b0, o_pe, o_fe, o_oe}, 32'h0);
      check("a5_idle", 32'(o_busy), 32'h0);
      read_pulse();
      check("a5_read", 32'(o_rdy), 32'h0);
      frame(1'b0, mk(9'h5A, 8, 0, 1'b0, 1, 1'b1), 10, -1, -1, 1'b0, -1, rise, bq);
      check("5a_data", 32'(o_data), 32'h5A);
      frame(1'b0, mk(9'h77, 8, 0, 1'b0, 1, 1'b0), 10, -1, -1, 1'b0, -1, rise, bq);
      check("fe_flag", 32'(o_fe), 32'h1);
      check("fe_keep_data", 32'(o_data), 32'h5A);
      check("fe_keep_rdy", 32'(o_rdy), 32'h1);
      check("fe_no_oe", 32'(o_oe), 32'h0);
      read_pulse();
      frame(1'b0, mk(9'h11, 8, 0, 1'b0, 1, 1'b1), 10, -1, -1, 1'b0, -1, rise, bq);
      check("fe_cleared", 32'(o_fe), 32'h0);
      check("11_data", 32'(o_data), 32'h11);
      frame(1'b0, mk(9'h22, 8, 0, 1'b0, 1, 1'b1), 10, -1, -1, 1'b0, -1, rise, bq);
      check("ovr_data", 32'(o_data), 32'h22);
      check("ovr_flag", 32'(o_oe), 32'h1);
      read_pulse();
      check("ovr_read_rdy", 32'(o_rdy), 32'h0);
      check("ovr_read_oe", 32'(o_oe), 32'h0);
      frame(1'b0, mk(9'h11, 8, 0, 1'b0, 1, 1'b1), 10, -1, -1, 1'b0, -1, rise, bq);
      frame(1'b0, mk(9'h22, 8, 0, 1'b0, 1, 1'b1), 10, -1, -1, 1'b1, -1, rise, bq);
      check("rdld_data", 32'(o_data), 32'h22);
      check("rdld_rdy", 32'(o_rdy), 32'h1);
      check("rdld_oe", 32'(o_oe), 32'h0);
      frame(1'b0, 16'hFFFF, 10, -1, -1, 1'b0, HALF + 1, rise, bq);
      check("false_busy", 32'(bq), 32'h0);
      check("false_no_rise", 32'(rise), 32'hFFFFFFFF);
      check("false_data", 32'(o_data), 32'h22);
      check("false_flags", {28'b0, o_rdy, o_pe, o_fe, o_oe}, 32'h8);
      read_pulse();
      frame(1'b0, mk(9'h96, 8, 0, 1'b0, 1, 1'b1), 10, 40, -1, 1'b0, -1, rise, bq);
      check("extra_rise", 32'(rise), 32'd97);
      check("extra_data", 32'(o_data), 32'h96);
      frame(1'b0, mk(9'hFF, 8, 0, 1'b0, 1, 1'b1), 10, -1, 40, 1'b0, -1, rise, bq);
      check("rst_no_rise", 32'(rise), 32'hFFFFFFFF);
      frame(1'b0, mk(9'h3C, 8, 0, 1'b0, 1, 1'b1), 10, -1, -1, 1'b0, -1, rise, bq);
      check("3c_rise", 32'(rise), 32'd97);
      check("3c_data", 32'(o_data), 32'h3C);
      check("3c_flags", {29'b0, o_pe, o_fe, o_oe}, 32'h0);
      frame(1'b1, mk(9'h41, 7, 1, 1'b1, 2, 1'b1), 11, -1, -1, 1'b0, -1, rise, bq);
      check("p_good_rise", 32'(rise), 32'd107);
      check("p_good_data", 32'(o_data), 32'h41);
      check("p_good_pe", 32'(o_pe), 32'h0);
      read_pulse();
      frame(1'b1, mk(9'h41, 7, 1, 1'b0, 2, 1'b1), 11, -1, -1, 1'b0, -1, rise, bq);
      check("p_bad_data", 32'(o_data), 32'h41);
      check("p_bad_rdy", 32'(o_rdy), 32'h1);
      check("p_bad_pe", 32'(o_pe), 32'h1);
      check("p_bad_fe", 32'(o_fe), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Parametrised receive controller for the UART receiver: integrates the bit-period timer, bit counter, data shift register, parity check and receive buffer that the earlier fixed-format receive FSM delegated to separate blocks. Data width, stop-bit count, parity mode and oversampling ratio are set per instance. Sits between the start-bit edge detector and the consumer's read interface, and adds parity and overrun detection.

## Interface
- DATA_BITS, 8, data bits per frame; legal 5..9; sent LSB first
- CLKS_PER_BIT, 10, clk cycles per serial bit; legal >= 4; HALF = CLKS_PER_BIT/2 (integer division)
- STOP_BITS, 1, stop bits per frame; legal 1..2
- PARITY_EN, 0, 1 = a parity bit follows the data bits
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset: asynchronous, active-high
- serial_in  in  1  synchronised serial line; idles high
- start_bit_detected  in  1  one-cycle pulse from the edge detector
- data_read  in  1  consumer acknowledge; pulse of one cycle or longer
- rx_data  out  DATA_BITS  receive buffer
- data_ready  out  1  receive buffer holds unread data
- parity_error  out  1  last completed frame failed the parity check
- framing_error  out  1  last completed frame had a stop bit sampled low
- overrun_error  out  1  an unread frame was overwritten
- busy  out  1  combinational; 1 whenever state != IDLE

## Operation
- States: IDLE, START, DATA, PARITY, STOP, LOAD. An internal timer (clog2(CLKS_PER_BIT) bits) and a bit counter are cleared on every state entry.
- IDLE: start_bit_detected = 1 -> START.
- START: sample serial_in when timer = HALF-1.
  - serial_in = 0 -> DATA.
  - serial_in = 1 is a false start -> IDLE; no flag changes.
- DATA: sample when timer = CLKS_PER_BIT-1, then clear the timer and shift the sample into the MSB of the shift register (LSB-first reception).
  - After DATA_BITS samples -> PARITY if PARITY_EN = 1, otherwise -> STOP.
- PARITY: sample at timer = CLKS_PER_BIT-1.
  - Expected bit = ^data when PARITY_ODD = 0, ~^data when PARITY_ODD = 1.
  - A mismatch latches an internal parity-fail bit.
- STOP: sample STOP_BITS bits, each at timer = CLKS_PER_BIT-1. Any stop bit sampled low latches an internal stop-fail bit. After the last stop bit -> LOAD.
- LOAD: one cycle, then -> IDLE. Updates on the clock edge that leaves LOAD:
  - framing_error <= stop-fail; parity_error <= parity-fail. Both are updated on every frame.
  - Stop-fail = 0: rx_data <= shift register; data_ready <= 1. If data_ready was already 1 and data_read = 0 in the LOAD cycle, overrun_error <= 1.
  - Stop-fail = 1: rx_data, data_ready and overrun_error are unchanged (the frame is discarded).
- data_read = 1 outside LOAD: data_ready <= 0 and overrun_error <= 0 on the next edge.
- data_read = 1 during LOAD with a good frame: the new data is loaded, data_ready stays 1, no overrun.
- start_bit_detected is ignored in every state except IDLE.

## Timing
- Reset (async assert, at any point including mid-frame): state = IDLE, timer, bit counter, shift register and internal fail bits = 0. Outputs: rx_data = 0, data_ready = 0, parity_error = 0, framing_error = 0, overrun_error = 0, busy = 0.
- Define cycle 0 as the cycle in which start_bit_detected is high in IDLE. N = DATA_BITS + PARITY_EN + STOP_BITS.
- The start bit is sampled in cycle HALF. Frame bit k (k = 0..N-1, counted after the start bit) is sampled in cycle HALF + (k+1)*CLKS_PER_BIT.
- LOAD is in cycle HALF + N*CLKS_PER_BIT + 1. data_ready and the flags are visible from cycle HALF + N*CLKS_PER_BIT + 2.
  - Default instance: bit samples at cycles 15, 25, ..., 95; data_ready rises at cycle 97.
- The earliest accepted back-to-back start pulse is the first cycle back in IDLE, cycle HALF + N*CLKS_PER_BIT + 2.
- A false start returns the block to IDLE in cycle HALF + 1.

## Test plan
- Default instance, frame 0xA5 with a good stop bit -> rx_data = 0xA5, data_ready rises at cycle 97, all error flags 0; data_read pulse -> data_ready = 0 on the next cycle.
- DATA_BITS = 7, PARITY_EN = 1, PARITY_ODD = 1, STOP_BITS = 2, frame 0x41:
  - parity bit 1 -> parity_error = 0;
  - parity bit 0 -> rx_data = 0x41, data_ready = 1, parity_error = 1.
- Stop bit driven low -> framing_error = 1; rx_data and data_ready keep their previous values. The next good frame clears framing_error.
- Two good frames (0x11 then 0x22) with no data_read -> rx_data = 0x22, overrun_error = 1; data_read clears overrun_error and data_ready. Repeat with data_read held high through the second LOAD -> overrun_error = 0.
- Start pulse with serial_in high at cycle HALF -> back in IDLE at cycle HALF+1, busy = 0, no output changes.
- Start pulse during DATA -> ignored, frame timing unchanged.
- rst asserted mid-frame at cycle 40 -> all outputs 0 immediately (asynchronous). Release rst and send a new frame 0x3C -> received correctly.
